// File: rtl/key_feeder.sv
// Periodic serializer that shifts a 64-bit licence key, MSB first, onto the
// watchdog's serial key port and repeats it every PERIOD clocks while enabled.
module key_feeder #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PERIOD  = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key,
    input  logic        enable,
    input  logic        kick,
    output logic        sclk,
    output logic        sdat,
    output logic        en,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } state_t;

    localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0] PER_LAST = 32'(PERIOD - 1);

    state_t      state, state_nxt;
    logic [31:0] div_cnt, div_nxt;
    logic [31:0] period_cnt, period_nxt;
    logic [5:0]  bit_cnt, bit_nxt;
    logic [63:0] shadow, shadow_nxt;
    logic        ending, ending_nxt;
    logic        start;

    logic sclk_nxt, sdat_nxt, en_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            period_cnt <= '0;
            bit_cnt    <= '0;
            shadow     <= '0;
            ending     <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            period_cnt <= period_nxt;
            bit_cnt    <= bit_nxt;
            shadow     <= shadow_nxt;
            ending     <= ending_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt;
        bit_nxt    = bit_cnt;
        shadow_nxt = shadow;
        ending_nxt = 1'b0;
        start      = 1'b0;
        period_nxt = (period_cnt == PER_LAST) ? period_cnt : period_cnt + 32'd1;

        case (state)
            IDLE: begin
                if (kick || enable) start = 1'b1;
            end
            GAP: begin
                if (kick || (enable && period_cnt == PER_LAST)) start = 1'b1;
                else if (!enable) state_nxt = IDLE;
            end
            LOW: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt   = '0;
                    state_nxt = HIGH;
                end else begin
                    div_nxt = div_cnt + 32'd1;
                end
            end
            HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt == 6'd0) begin
                        ending_nxt = 1'b1;
                        state_nxt  = enable ? GAP : IDLE;
                    end else begin
                        shadow_nxt = {shadow[62:0], 1'b0};
                        bit_nxt    = bit_cnt - 6'd1;
                        state_nxt  = LOW;
                    end
                end else begin
                    div_nxt = div_cnt + 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            shadow_nxt = key;
            bit_nxt    = 6'd63;
            period_nxt = '0;
            div_nxt    = '0;
            state_nxt  = LOW;
        end
    end

    // Port outputs are a registered image of the current state, so every
    // output lags the FSM by one clock and none depends on an input directly.
    always_comb begin
        en_nxt   = (state == LOW) || (state == HIGH);
        sclk_nxt = (state == HIGH);
        sdat_nxt = en_nxt & shadow[63];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk       <= 1'b0;
            sdat       <= 1'b0;
            en         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sclk       <= sclk_nxt;
            sdat       <= sdat_nxt;
            en         <= en_nxt;
            busy       <= en_nxt;
            frame_done <= ending;
        end
    end

endmodule

// File: tb/tb_key_feeder.sv
// Randomized scoreboard bench for key_feeder: the stimulus side predicts frame
// start times and keys, a receiver-model monitor checks each delivered frame.
module tb_key_feeder;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned PERIOD  = 600;
    localparam int unsigned FRAME   = 128 * CLK_DIV;

    logic        clk;
    logic        rst_n;
    logic [63:0] key;
    logic        enable;
    logic        kick;
    logic        sclk;
    logic        sdat;
    logic        en;
    logic        busy;
    logic        frame_done;

    key_feeder #(
        .CLK_DIV(CLK_DIV),
        .PERIOD (PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .enable    (enable),
        .kick      (kick),
        .sclk      (sclk),
        .sdat      (sdat),
        .en        (en),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] key;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // A frame latched at edge s is fully delivered, frame_done visible, after edge s+1+FRAME.
    task automatic push(input int unsigned s, input logic [63:0] k);
        exp_t e;
        e.key      = k;
        e.done_cyc = s + 1 + FRAME;
        sb.push_back(e);
    endtask

    task automatic goto(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] rand_key();
        return {$urandom, $urandom};
    endfunction

    // Receiver model: shifts sdat on each sclk rise while en is high.
    initial begin : monitor
        logic [63:0] rx;
        int unsigned rises, en_cnt;
        logic        prev_sclk, prev_sdat, prev_en;
        exp_t        e;
        rx = '0; rises = 0; en_cnt = 0;
        prev_sclk = 1'b0; prev_sdat = 1'b0; prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx = '0; rises = 0; en_cnt = 0;
                prev_sclk = 1'b0; prev_sdat = 1'b0; prev_en = 1'b0;
            end else begin
                if (sclk && !prev_sclk && en) begin
                    rx = {rx[62:0], sdat};
                    rises++;
                end
                if (sclk && prev_sclk) begin
                    check("sdat_hold_while_sclk_high", 64'(sdat), 64'(prev_sdat));
                    check("en_hold_while_sclk_high", 64'(en), 64'(prev_en));
                end
                if (en) en_cnt++;
                if (frame_done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got frame_done at cycle %0d, required none", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("frame_key", rx, e.key);
                        check("frame_done_cycle", 64'(cyc), 64'(e.done_cyc));
                        check("en_cycles", 64'(en_cnt), 64'(FRAME));
                        check("sclk_rises", 64'(rises), 64'd64);
                    end
                    rx = '0; rises = 0; en_cnt = 0;
                end
                prev_sclk = sclk;
                prev_sdat = sdat;
                prev_en   = en;
            end
        end
    end

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not complete, required completion within 100000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int unsigned s, d;
        logic [63:0] k;
        rst_n = 1'b0; enable = 1'b0; kick = 1'b0; key = '0;
        @(posedge clk);
        #1;
        goto(3);
        check("reset_sclk", 64'(sclk), 64'd0);
        check("reset_sdat", 64'(sdat), 64'd0);
        check("reset_en", 64'(en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;

        // Basic periodic frames, then a key change at bit 20 of the second frame.
        goto(10);
        key = 64'h0123456789ABCDEF;
        enable = 1'b1;
        s = 11;
        push(s, 64'h0123456789ABCDEF);
        push(s + PERIOD, 64'h0123456789ABCDEF);
        goto(s + PERIOD + 1 + 20 * 2 * CLK_DIV);
        key = '1;
        s = s + 2 * PERIOD;
        push(s, '1);

        // Kick in the gap 100 cycles after frame_done restarts the period.
        d = s + 1 + FRAME;
        goto(d + 100);
        k = rand_key();
        key = k;
        kick = 1'b1;
        s = d + 101;
        push(s, k);
        goto(s);
        kick = 1'b0;
        goto(s + 5);
        k = rand_key();
        key = k;
        s = s + PERIOD;
        push(s, k);

        // Kick mid-frame is ignored.
        goto(s + 1 + $urandom_range(0, 250));
        kick = 1'b1;
        goto(cyc + 1);
        kick = 1'b0;
        k = rand_key();
        key = k;
        s = s + PERIOD;
        push(s, k);

        // Enable dropped at bit 10: frame completes, nothing follows.
        goto(s + 1 + 10 * 2 * CLK_DIV);
        enable = 1'b0;
        goto(s + 1500);
        check("idle_busy_after_enable_drop", 64'(busy), 64'd0);

        // Reset at bit 30 abandons the frame; a fresh one follows release.
        k = rand_key();
        key = k;
        enable = 1'b1;
        s = cyc + 1;
        goto(s + 1 + 30 * 2 * CLK_DIV);
        rst_n = 1'b0;
        #1;
        check("midreset_sclk", 64'(sclk), 64'd0);
        check("midreset_sdat", 64'(sdat), 64'd0);
        check("midreset_en", 64'(en), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        goto(s + 125);
        k = rand_key();
        key = k;
        rst_n = 1'b1;
        s = s + 126;
        push(s, k);
        goto(s + 1);
        check("restart_en", 64'(en), 64'd1);
        check("restart_sclk", 64'(sclk), 64'd0);
        check("restart_sdat", 64'(sdat), 64'(k[63]));
        enable = 1'b0;
        goto(s + 800);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
